// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU snoop inputs, DMA read port and
// PPU register write port. master = the DMA engine, slave = its environment.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_reg_we;
  logic [7:0]  ppu_wdata;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output mem_addr, mem_rd, ppu_reg_cs, ppu_reg_addr, ppu_reg_we, ppu_wdata
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  mem_addr, mem_rd, ppu_reg_cs, ppu_reg_addr, ppu_reg_we, ppu_wdata
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one
// 256-byte CPU page into PPU OAMDATA, one read cycle plus one write cycle per byte.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_IDX  = 3'd4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cpu_ce,
  oam_dma_if.master  bus,
  output logic       dma_rdy,
  output logic       busy,
  output logic       dma_done
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state, state_n;
  logic        parity;
  logic [7:0]  page, page_n;
  logic [7:0]  idx, idx_n;
  logic [7:0]  data_q, data_q_n;
  logic        done_n;

  // next-cycle output values; registered on the same cpu_ce edge as the state
  logic        rdy_d, busy_d, mem_rd_d, cs_d, we_d;
  logic [15:0] mem_addr_d;
  logic [2:0]  reg_addr_d;
  logic [7:0]  wdata_d;

  logic trig;
  assign trig = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

  // State and datapath registers; everything advances only on cpu_ce edges.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
    end else if (cpu_ce) begin
      state  <= state_n;
      parity <= ~parity;
      page   <= page_n;
      idx    <= idx_n;
      data_q <= data_q_n;
    end
  end

  // Next-state logic; the 255 check precedes the increment so byte 256 ends it.
  always_comb begin
    state_n  = state;
    page_n   = page;
    idx_n    = idx;
    data_q_n = data_q;
    done_n   = 1'b0;
    case (state)
      IDLE: if (trig) begin
        state_n = HALT;
        page_n  = bus.cpu_wdata;
        idx_n   = 8'h00;
      end
      HALT:  state_n = parity ? ALIGN : READ;
      ALIGN: state_n = READ;
      READ: begin
        data_q_n = bus.mem_rdata;
        state_n  = WRITE;
      end
      WRITE: begin
        idx_n = idx + 8'd1;
        if (idx == 8'hFF) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = READ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the cycle the state machine is in.
  always_comb begin
    rdy_d      = (state_n == IDLE);
    busy_d     = (state_n != IDLE);
    mem_rd_d   = (state_n == READ);
    mem_addr_d = (state_n == READ) ? {page_n, idx_n} : 16'h0000;
    cs_d       = (state_n == WRITE);
    we_d       = (state_n == WRITE);
    reg_addr_d = (state_n == WRITE) ? OAMDATA_IDX : 3'd0;
    wdata_d    = (state_n == WRITE) ? data_q_n : bus.ppu_wdata;
  end

  // Registered outputs; dma_done is a single CLOCK_50 pulse, cleared on the next clock.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dma_rdy          <= 1'b1;
      busy             <= 1'b0;
      dma_done         <= 1'b0;
      bus.mem_rd       <= 1'b0;
      bus.mem_addr     <= 16'h0000;
      bus.ppu_reg_cs   <= 1'b0;
      bus.ppu_reg_we   <= 1'b0;
      bus.ppu_reg_addr <= 3'd0;
      bus.ppu_wdata    <= 8'h00;
    end else begin
      dma_done <= cpu_ce && done_n;
      if (cpu_ce) begin
        dma_rdy          <= rdy_d;
        busy             <= busy_d;
        bus.mem_rd       <= mem_rd_d;
        bus.mem_addr     <= mem_addr_d;
        bus.ppu_reg_cs   <= cs_d;
        bus.ppu_reg_we   <= we_d;
        bus.ppu_reg_addr <= reg_addr_d;
        bus.ppu_wdata    <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: per-CPU-cycle output log compared against
// a cycle-numbered model of the transfer timeline.
module tb_oam_dma;
  localparam int LOGN = 4096;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic cpu_ce   = 1'b0;
  logic dma_rdy, busy, dma_done;
  bit   stall_en = 1'b0;
  int   gap_cnt  = 0;

  int n_cmp = 0;
  int n_bad = 0;

  oam_dma_if bus();

  oam_dma #(.DMA_REG_ADDR(16'h4014), .OAMDATA_IDX(3'd4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cpu_ce   (cpu_ce),
    .bus      (bus.master),
    .dma_rdy  (dma_rdy),
    .busy     (busy),
    .dma_done (dma_done)
  );

  // memory model: data = low address byte ^ A5
  assign bus.mem_rdata = bus.mem_addr[7:0] ^ 8'hA5;

  always #5 CLOCK_50 = ~CLOCK_50;

  // cpu_ce generator: every clock, or with random 1..5 clock gaps
  always @(negedge CLOCK_50) begin
    if (!stall_en) cpu_ce = 1'b1;
    else if (gap_cnt == 0) begin
      cpu_ce  = 1'b1;
      gap_cnt = $urandom_range(1, 5);
    end else begin
      cpu_ce  = 1'b0;
      gap_cnt = gap_cnt - 1;
    end
  end

  // CPU cycle number since reset (cycle c is after c cpu_ce edges)
  int   cyc;
  logic ce_seen;
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cyc     <= 0;
      ce_seen <= 1'b0;
    end else begin
      ce_seen <= cpu_ce;
      if (cpu_ce) cyc <= cyc + 1;
    end
  end

  // per-cycle output log, taken on the first falling edge of each CPU cycle
  logic        l_rdy [LOGN];
  logic        l_busy[LOGN];
  logic        l_rd  [LOGN];
  logic        l_cs  [LOGN];
  logic        l_we  [LOGN];
  logic [15:0] l_addr[LOGN];
  logic [2:0]  l_ra  [LOGN];
  logic [7:0]  l_wd  [LOGN];
  int          done_cnt = 0;

  always @(negedge CLOCK_50) begin
    if (!reset && dma_done === 1'b1) done_cnt++;
    if (!reset && ce_seen && cyc < LOGN) begin
      l_rdy[cyc]  = dma_rdy;
      l_busy[cyc] = busy;
      l_rd[cyc]   = bus.mem_rd;
      l_cs[cyc]   = bus.ppu_reg_cs;
      l_we[cyc]   = bus.ppu_reg_we;
      l_addr[cyc] = bus.mem_addr;
      l_ra[cyc]   = bus.ppu_reg_addr;
      l_wd[cyc]   = bus.ppu_wdata;
    end
  end

  task automatic do_reset();
    @(posedge CLOCK_50);
    #2 reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  // wait until the CPU cycle counter reaches target, bounded
  task automatic wait_cyc(input int target);
    int budget = 40000;
    while (cyc < target && budget > 0) begin
      @(negedge CLOCK_50);
      budget--;
    end
    if (cyc < target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, target);
    end
  endtask

  // one CPU bus cycle; want_a >= 0 picks a cycle T so that parity in T+1 == want_a
  task automatic cpu_cycle(input logic [15:0] addr, input logic [7:0] data,
                           input logic we, input int want_a, output int t);
    int budget = 1000;
    @(negedge CLOCK_50);
    while (budget > 0 && !(ce_seen && (want_a < 0 || ((cyc + 1) & 1) == want_a))) begin
      @(negedge CLOCK_50);
      budget--;
    end
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    bus.cpu_we    = we;
    t = cyc;
    budget = 1000;
    do begin
      @(posedge CLOCK_50);
      budget--;
    end while (!cpu_ce && budget > 0);
    @(negedge CLOCK_50);
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0000;
  endtask

  // Reference timeline: trigger ends cycle T, a = parity in T+1 = (T+1)&1,
  // byte i read in T+2+a+2i and written in T+3+a+2i, busy through T+513+a.
  task automatic scan_xfer(input int t, input logic [7:0] pg, output int rdy_low,
                           output int seq_err, output int nwr, output int first_rd);
    int a, last, rel, i;
    logic e_rdy, e_rd, e_cs, chk_wd;
    logic [15:0] e_addr;
    logic [2:0]  e_ra;
    logic [7:0]  e_wd;
    a = (t + 1) & 1;
    last = t + 513 + a;
    rdy_low = 0; seq_err = 0; nwr = 0; first_rd = -1;
    for (int c = t + 1; c <= last + 4; c++) begin
      e_rdy = (c > last); e_rd = 1'b0; e_cs = 1'b0; e_addr = 16'h0;
      e_ra = 3'd0; e_wd = 8'h00; chk_wd = 1'b0;
      if (c <= last) begin
        rel = c - (t + 2 + a);
        if (rel >= 0) begin
          i = rel / 2;
          if (rel % 2 == 0) begin
            e_rd = 1'b1; e_addr = {pg, 8'(i)};
          end else begin
            e_cs = 1'b1; e_ra = 3'd4; e_wd = 8'(i) ^ 8'hA5; chk_wd = 1'b1;
          end
        end
      end
      if (l_rdy[c] === 1'b0) rdy_low++;
      if (l_rd[c] === 1'b1 && first_rd < 0) first_rd = c - t;
      if (l_cs[c] === 1'b1 && l_we[c] === 1'b1) nwr++;
      if (l_rdy[c] !== e_rdy || l_busy[c] !== !e_rdy || l_rd[c] !== e_rd ||
          l_addr[c] !== e_addr || l_cs[c] !== e_cs || l_we[c] !== e_cs ||
          l_ra[c] !== e_ra || (chk_wd && l_wd[c] !== e_wd))
        seq_err++;
    end
  endtask

  task automatic test_reset();
    int t;
    logic [32:0] obs;
    do_reset();
    cpu_cycle(16'h4014, 8'h33, 1'b1, -1, t);
    wait_cyc(t + 30);
    @(posedge CLOCK_50);
    #3 reset = 1'b1;
    #1 obs = {dma_rdy, busy, dma_done, bus.mem_rd, bus.ppu_reg_cs, bus.ppu_reg_we,
              bus.mem_addr, bus.ppu_reg_addr, bus.ppu_wdata};
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", obs,
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 8'h00});
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic test_xfer(input string nm, input logic [7:0] pg, input int want_a);
    int t, d0, rl, se, nw, fr;
    do_reset();
    d0 = done_cnt;
    cpu_cycle(16'h4014, pg, 1'b1, want_a, t);
    wait_cyc(t + 520 + want_a);
    scan_xfer(t, pg, rl, se, nw, fr);
    n_cmp++;
    if (rl !== 513 + want_a) begin n_bad++; $display("FAIL %s_rdy_low: got %0d want %0d", nm, rl, 513 + want_a); end
    n_cmp++;
    if (se !== 0) begin n_bad++; $display("FAIL %s_sequence: got %0d bad cycles want 0", nm, se); end
    n_cmp++;
    if (nw !== 256) begin n_bad++; $display("FAIL %s_writes: got %0d want 256", nm, nw); end
    n_cmp++;
    if (fr !== 2 + want_a) begin n_bad++; $display("FAIL %s_first_read: got T+%0d want T+%0d", nm, fr, 2 + want_a); end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL %s_done: got %0d pulses want 1", nm, done_cnt - d0); end
  endtask

  task automatic test_non_trigger();
    int t1, t2, low;
    do_reset();
    cpu_cycle(16'h4015, 8'($urandom), 1'b1, -1, t1);
    cpu_cycle(16'h4014, 8'($urandom), 1'b0, -1, t2);
    wait_cyc(t2 + 10);
    low = 0;
    for (int c = t1 + 1; c <= t2 + 9; c++) if (l_rdy[c] !== 1'b1) low++;
    n_cmp++;
    if (low !== 0) begin n_bad++; $display("FAIL nontrig_rdy: got %0d halted cycles want 0", low); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL nontrig_busy: got %b want 0", busy); end
  endtask

  task automatic test_double_trigger();
    int t, t2, rl, se, nw, fr, a;
    logic [7:0] pg;
    pg = 8'($urandom);
    do_reset();
    cpu_cycle(16'h4014, pg, 1'b1, -1, t);
    a = (t + 1) & 1;
    wait_cyc(t + 50);
    cpu_cycle(16'h4014, ~pg, 1'b1, -1, t2);
    wait_cyc(t + 520 + a);
    scan_xfer(t, pg, rl, se, nw, fr);
    n_cmp++;
    if (nw !== 256) begin n_bad++; $display("FAIL double_writes: got %0d want 256", nw); end
    n_cmp++;
    if (se !== 0) begin n_bad++; $display("FAIL double_sequence: got %0d bad cycles want 0", se); end
    n_cmp++;
    if (rl !== 513 + a) begin n_bad++; $display("FAIL double_rdy_low: got %0d want %0d", rl, 513 + a); end
  endtask

  task automatic test_reset_mid();
    int t, a, rl, se, nw, fr;
    logic [32:0] obs;
    do_reset();
    cpu_cycle(16'h4014, 8'($urandom), 1'b1, -1, t);
    a = (t + 1) & 1;
    wait_cyc(t + 4 + a + 200);
    @(posedge CLOCK_50);
    #2 reset = 1'b1;
    #1 obs = {dma_rdy, busy, dma_done, bus.mem_rd, bus.ppu_reg_cs, bus.ppu_reg_we,
              bus.mem_addr, bus.ppu_reg_addr, bus.ppu_wdata};
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 8'h00}) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h want %h", obs,
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 8'h00});
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    cpu_cycle(16'h4014, 8'h07, 1'b1, -1, t);
    a = (t + 1) & 1;
    wait_cyc(t + 520 + a);
    scan_xfer(t, 8'h07, rl, se, nw, fr);
    n_cmp++;
    if (se !== 0) begin n_bad++; $display("FAIL midreset_sequence: got %0d bad cycles want 0", se); end
    n_cmp++;
    if (nw !== 256) begin n_bad++; $display("FAIL midreset_writes: got %0d want 256", nw); end
    n_cmp++;
    if (fr !== 2 + a) begin n_bad++; $display("FAIL midreset_first_read: got T+%0d want T+%0d", fr, 2 + a); end
    n_cmp++;
    if (rl !== 513 + a) begin n_bad++; $display("FAIL midreset_rdy_low: got %0d want %0d", rl, 513 + a); end
  endtask

  initial begin
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    bus.cpu_we    = 1'b0;
    test_reset();
    test_xfer("even", 8'h02, 0);
    test_xfer("odd", 8'($urandom), 1);
    test_non_trigger();
    test_double_trigger();
    test_reset_mid();
    stall_en = 1'b1;
    test_xfer("stall", 8'h02, 0);
    stall_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
